// File: rtl/ca_debounce.sv
// ca_debounce: two-flop synchronizer followed by a stability-count filter for one raw board input.
// Optional macro CA_DEBOUNCE_EDGE_EN adds registered single-cycle Rise/Fall pulses on Out changes.
module ca_debounce #(
  parameter int CNT_W      = 20,
  parameter int STABLE_CNT = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic In,
`ifdef CA_DEBOUNCE_EDGE_EN
  output logic Rise,
  output logic Fall,
`endif
  output logic Out
);

  // Outputs are plain levels/pulses with no valid/ready handshake: the consumer samples every cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             mismatch;
  logic             fire;

  // The block is IDLE while s2 matches Out and cnt is 0, COUNTING otherwise; cnt is the only state.
  assign mismatch = (s2 != Out);
  assign fire     = mismatch && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      Out <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= In;
      s2 <= s1;
      if (!mismatch) begin
        cnt <= '0;
      end else if (fire) begin
        Out <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef CA_DEBOUNCE_EDGE_EN
  // Pulses are registered on the same edge that updates Out, so they line up with its new value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Rise <= 1'b0;
      Fall <= 1'b0;
    end else begin
      Rise <= fire && s2;
      Fall <= fire && !s2;
    end
  end
`endif

endmodule

// File: tb/tb_ca_debounce.sv
// tb_ca_debounce: directed scoreboard bench for ca_debounce with CNT_W=3, STABLE_CNT=4.
// Rise/Fall are checked only when CA_DEBOUNCE_EDGE_EN is defined for the build.
module tb_ca_debounce;

  logic clk;
  logic rst;
  logic din;
  logic dout;
`ifdef CA_DEBOUNCE_EDGE_EN
  logic rise;
  logic fall;
`endif

  int test_cnt;
  int fail_cnt;

  // Each entry is {out, rise, fall} expected after the edge that consumes the matching step.
  logic [2:0] exp_q[$];

  ca_debounce #(
    .CNT_W(3),
    .STABLE_CNT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .In(din),
`ifdef CA_DEBOUNCE_EDGE_EN
    .Rise(rise),
    .Fall(fall),
`endif
    .Out(dout)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [2:0] e);
    check({tag, ".out"}, dout, e[2]);
`ifdef CA_DEBOUNCE_EDGE_EN
    check({tag, ".rise"}, rise, e[1]);
    check({tag, ".fall"}, fall, e[0]);
`endif
  endtask

  // Driver: called 1 time unit after a rising edge; drives In, queues the expectation,
  // then samples 1 time unit after the next edge and scores it.
  task automatic step(input string tag, input logic v, input logic o, input logic r, input logic f);
    logic [2:0] e;
    din = v;
    exp_q.push_back({o, r, f});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      test_cnt++;
      fail_cnt++;
      $error("FAIL %s: observed empty queue expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      check_outputs(tag, e);
    end
  endtask

  // Hold In at v for the full transition: Out changes after edge 6, pulse for one cycle.
  task automatic transition(input string tag, input logic v);
    for (int i = 1; i <= 5; i++) step(tag, v, ~v, 1'b0, 1'b0);
    step(tag, v, v, v, ~v);
    step(tag, v, v, 1'b0, 1'b0);
    step(tag, v, v, 1'b0, 1'b0);
  endtask

  initial begin
    test_cnt = 0;
    fail_cnt = 0;
    rst = 1'b1;
    din = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset_init", 3'b000);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Clean press
    transition("press", 1'b1);

    // Asynchronous reset while Out=1 and In=1: outputs drop with no clock edge
    #2;
    rst = 1'b1;
    #1;
    check_outputs("reset_async", 3'b000);
    @(posedge clk);
    #1;
    check_outputs("reset_held", 3'b000);
    rst = 1'b0;
    transition("reset_relatch", 1'b1);

    // Release
    transition("release", 1'b0);

    // Bounce rejection: runs of three never reach STABLE_CNT
    begin
      logic [7:0] pat;
      pat = 8'b0111_0111;
      for (int i = 7; i >= 0; i--) step("bounce", pat[i], 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step("bounce_tail", 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Bounce then settle: final held 1 first sampled on edge 5, Out rises after edge 10
    step("settle", 1'b1, 1'b0, 1'b0, 1'b0);
    step("settle", 1'b0, 1'b0, 1'b0, 1'b0);
    step("settle", 1'b1, 1'b0, 1'b0, 1'b0);
    step("settle", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 5; i <= 9; i++) step("settle", 1'b1, 1'b0, 1'b0, 1'b0);
    step("settle_rise", 1'b1, 1'b1, 1'b1, 1'b0);
    step("settle_hold", 1'b1, 1'b1, 1'b0, 1'b0);

    transition("release2", 1'b0);

    // Reset mid-count: four edges into a press, then the full latency restarts
    for (int i = 0; i < 4; i++) step("midcount", 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("midcount_rst", 3'b000);
    rst = 1'b0;
    transition("midcount_restart", 1'b1);

    test_cnt++;
    assert (exp_q.size() == 0) else begin
      fail_cnt++;
      $error("FAIL queue_drain: observed %0d entries expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/ca_debounce.md
# ca_debounce

Synchronizing debouncer for one raw board input (push-button or slide switch). It samples the asynchronous `In` level, filters out bounce shorter than a programmable number of clock cycles, and drives a clean, registered level on `Out`. It sits directly upstream of the single-bit combinational stages in the lab designs, such as the inverter that drives an LED, and feeds them a glitch-free signal.

## Interface
Parameters:
- `CNT_W`, default 20: stability counter width in bits.
- `STABLE_CNT`, default 1000000: number of consecutive mismatching cycles required before `Out` changes. Legal range is 1 ≤ STABLE_CNT ≤ 2^CNT_W.

Ports:
- `clk`, input, 1 bit: the only clock. All state updates on its rising edge.
- `rst`, input, 1 bit: reset, asynchronous and active-high.
- `In`, input, 1 bit: raw, asynchronous, bouncing input level.
- `Out`, output, 1 bit: debounced level, registered.
- `Rise`, output, 1 bit: single-cycle pulse when `Out` goes 0→1. Present only with `CA_DEBOUNCE_EDGE_EN`.
- `Fall`, output, 1 bit: single-cycle pulse when `Out` goes 1→0. Present only with `CA_DEBOUNCE_EDGE_EN`.

## Operation
- **Synchronizer.** `In` passes through two flops, `s1` then `s2`. Only `s2` is used downstream.
- **Filter state.** Registered `Out` and a counter `cnt`, `CNT_W` bits wide.
- **Per rising edge**, in priority order:
  - If `s2 == Out`: `cnt <= 0`. `Out` holds.
  - Else, if `cnt == STABLE_CNT-1`: `Out <= s2` and `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
- **Glitch rejection.** Any single cycle with `s2 == Out` restarts the count from 0. A bounce shorter than `STABLE_CNT` cycles never reaches `Out`.
- **No wrap-around.** `cnt` never exceeds `STABLE_CNT-1`, so it cannot wrap for any legal parameter value.
- **Two-state behaviour.** The block is effectively an IDLE/COUNTING machine, where COUNTING means `cnt != 0` or `s2 != Out`. It needs no explicit state register beyond `cnt`.
- **Reset**, asynchronous, any time including mid-count: `s1`, `s2`, `Out`, `cnt`, `Rise` and `Fall` all go to 0 immediately. After reset deassertion, a held-high `In` is treated as a new transition and needs the full latency before `Out` rises.

## Timing
- **Reset values.** `Out = 0`, `Rise = 0`, `Fall = 0`.
- **Latency.** Number the rising edge that first captures the new `In` level into `s1` as edge 1. With `In` then stable, `Out` takes the new value after edge `STABLE_CNT+2`.
- **Minimum case.** With STABLE_CNT=1, `Out` follows `In` after 3 edges; this is the pure synchronizer plus one filter cycle.
- **Edge pulses.** `Rise` or `Fall` is high for exactly the one cycle in which `Out` first shows its new value. They are registered in the same edge that updates `Out`, and are never both high.
- **Transition rate.** `Out` changes at most once per `STABLE_CNT` cycles.
- **No handshakes.** Outputs are level or pulse only. The consumer must sample `Rise` and `Fall` every cycle.

## Configuration
- **Macro:** `CA_DEBOUNCE_EDGE_EN`.
- **Defined:** the `Rise` and `Fall` ports and their registers exist and behave as described above.
- **Undefined:** the `Rise` and `Fall` ports are absent and no edge registers are built. `Out` behaviour and latency are identical in both builds.

## Test plan
All scenarios use CNT_W=3 and STABLE_CNT=4.
- **Reset.** Assert `rst` mid-cycle with `In=1`. `Out`, `Rise` and `Fall` drop to 0 without waiting for a clock edge. Release `rst` and keep `In=1`. `Out` rises after edge 6; `Rise` is high for that one cycle only.
- **Clean press.** With `Out=0`, set `In` 0→1 before edge 1 and hold. `Out=1` after edge 6, not earlier. `Rise` pulses once, `Fall` stays 0.
- **Bounce rejection.** With `Out=0`, apply `In` = 1,1,1,0,1,1,1,0 sampled on successive edges, then 0. `Out` stays 0 throughout. `Rise` never asserts.
- **Bounce then settle.** Apply `In` = 1,0,1,0 and then 1 held. `Out=1` exactly 6 edges after the first sample of the final, held 1.
- **Release.** With `Out=1`, set `In` 1→0 and hold. `Out=0` after edge 6. `Fall` pulses one cycle.
- **Reset mid-count.** With `Out=0`, set `In=1`. After edge 4, pulse `rst`. `Out` stays 0. After release with `In=1` held, the full 6-edge latency restarts.
